// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one immediate-extension unit between two requesters,
// with a one-entry registered result slot and valid/ready handshakes on all sides.
module ext_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_imm,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_imm,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data
);

    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t       slot_p1;
    logic        vld_p1;
    logic        id_p1;
    logic [31:0] data_p1;
    logic        ptr;

    logic        slot_free;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic [1:0]  sel_op_p0;
    logic [15:0] sel_imm_p0;

    function automatic logic [31:0] extend(input logic [1:0] op, input logic [15:0] imm);
        logic signed [15:0] simm;
        logic signed [31:0] sext;
        simm = signed'(imm);
        sext = simm;
        case (op)
            2'b00:   extend = {16'h0000, imm};
            2'b01:   extend = unsigned'(sext);
            2'b10:   extend = {imm, 16'h0000};
            default: extend = 32'h0000_0000;
        endcase
    endfunction

    // Grants are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        slot_free  = (slot_p1 == EMPTY) || resp_ready;
        gnt0       = reset_n && slot_free && req0_valid && (!req1_valid || (ptr == 1'b0));
        gnt1       = reset_n && slot_free && req1_valid && (!req0_valid || (ptr == 1'b1));
        accept     = gnt0 || gnt1;
        sel_op_p0  = gnt1 ? req1_op  : req0_op;
        sel_imm_p0 = gnt1 ? req1_imm : req0_imm;
    end

    // Stage p0 -> p1: extend the granted request into the output slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_p1 <= EMPTY;
            vld_p1  <= 1'b0;
            id_p1   <= 1'b0;
            data_p1 <= 32'h0000_0000;
            ptr     <= FIRST_PRIO;
        end else begin
            case (slot_p1)
                EMPTY: begin
                    if (accept) begin
                        slot_p1 <= FULL;
                        vld_p1  <= 1'b1;
                    end
                end
                FULL: begin
                    if (resp_ready && !accept) begin
                        slot_p1 <= EMPTY;
                        vld_p1  <= 1'b0;
                    end
                end
                default: begin
                    slot_p1 <= EMPTY;
                    vld_p1  <= 1'b0;
                end
            endcase
            if (accept) begin
                id_p1   <= gnt1;
                data_p1 <= extend(sel_op_p0, sel_imm_p0);
                ptr     <= gnt0;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign resp_valid = vld_p1;
    assign resp_id    = id_p1;
    assign resp_data  = data_p1;

endmodule

// File: tb/tb_ext_arbiter.sv
// Scoreboard bench for ext_arbiter: a behavioural model predicts grants and results,
// a separate monitor pops expected responses whenever the consumer takes one.
module tb_ext_arbiter;

    localparam bit FP = 1'b0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [15:0] req0_imm = '0, req1_imm = '0;
    logic        req0_ready, req1_ready, resp_valid, resp_id;
    logic [31:0] resp_data;

    ext_arbiter #(.FIRST_PRIO(FP)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_imm(req1_imm),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_full = 1'b0;
    bit          m_ptr  = FP;
    bit          mon_en = 1'b0;
    bit          acc0, acc1;
    bit          v0 = 0, v1 = 0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic [15:0] imm0 = '0, imm1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Extension rules written as plain arithmetic on the unsigned immediate
    function automatic logic [31:0] model_ext(input logic [1:0] op, input logic [15:0] imm);
        int unsigned u;
        u = imm;
        case (op)
            2'd0:    return u;
            2'd1:    return (u >= 32768) ? u + 32'hFFFF_0000 : u;
            2'd2:    return u * 65536;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: apply the stimulus, compare handshake outputs, predict accepts.
    task automatic step(input bit rr);
        bit e0, e1;
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_imm = imm0;
        req1_valid = v1; req1_op = op1; req1_imm = imm1;
        resp_ready = rr;
        #1;
        e0 = v0 && (!v1 || !m_ptr) && (!m_full || rr);
        e1 = v1 && (!v0 ||  m_ptr) && (!m_full || rr);
        chk("resp_valid", 32'(resp_valid), 32'(m_full));
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        acc0 = e0;
        acc1 = e1;
        if (e0) begin
            exp_q.push_back('{id: 1'b0, data: model_ext(op0, imm0)});
            m_ptr = 1'b1;
        end else if (e1) begin
            exp_q.push_back('{id: 1'b1, data: model_ext(op1, imm1)});
            m_ptr = 1'b0;
        end
        m_full = e0 || e1 || (m_full && !rr);
    endtask

    // Monitor: every handshake on the response side must match the queue head.
    bit          hold_prev = 1'b0;
    logic        hold_id;
    logic [31:0] hold_data;
    resp_t       r_mon;
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (hold_prev && resp_valid) begin
                chk("held_id", 32'(resp_id), 32'(hold_id));
                chk("held_data", resp_data, hold_data);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_resp: got id=%0d data=%0h expected no response", resp_id, resp_data);
                end else begin
                    r_mon = exp_q.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(r_mon.id));
                    chk("resp_data", resp_data, r_mon.data);
                end
            end
            hold_prev = resp_valid && !resp_ready;
            hold_id   = resp_id;
            hold_data = resp_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        // Reset state, with both requesters asserting valid
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        #12;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // T1: single zero-extend from requester 0
        v0 = 1; op0 = 2'd0; imm0 = 16'd10;
        step(1);
        v0 = 0;
        step(1);

        // T2: requester 1, zero then sign extension of 0xFFFF
        v1 = 1; op1 = 2'd0; imm1 = 16'hFFFF;
        step(1);
        op1 = 2'd1;
        step(1);
        v1 = 0;
        step(1);

        // T3: continuous contention alternates owners
        v0 = 1; op0 = 2'd1; imm0 = 16'hFFF6;
        v1 = 1; op1 = 2'd2; imm1 = 16'h1234;
        repeat (6) step(1);

        // T4: consumer stalls with the slot full, then releases without a bubble
        repeat (5) step(0);
        repeat (3) step(1);

        // T5: reserved op still produces a zero result
        v0 = 0; v1 = 1; op1 = 2'd3; imm1 = 16'hABCD;
        step(1);
        v1 = 0;
        step(1);

        // T6: async reset while the slot is full
        v0 = 1; op0 = 2'd0; imm0 = 16'h5555;
        step(0);
        v0 = 0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        mon_en  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("t6_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_resp_data", resp_data, 32'd0);
        chk("t6_resp_id", 32'(resp_id), 32'd0);
        chk("t6_req0_ready", 32'(req0_ready), 32'd0);
        chk("t6_req1_ready", 32'(req1_ready), 32'd0);
        exp_q.delete();
        m_full = 1'b0;
        m_ptr  = FP;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        v0 = 1; op0 = 2'd0; imm0 = 16'h0001;
        v1 = 1; op1 = 2'd0; imm1 = 16'h0002;
        step(1);
        chk("t6_first_grant_req0", 32'(acc0), 32'(FP == 1'b0));
        step(1);
        v0 = 0; v1 = 0;
        step(1);

        // Randomised traffic; requesters hold their request until accepted
        for (int i = 0; i < 400; i++) begin
            if (!v0 && ($urandom_range(0, 1) == 1)) begin
                v0 = 1; op0 = 2'($urandom_range(0, 3)); imm0 = 16'($urandom);
            end
            if (!v1 && ($urandom_range(0, 1) == 1)) begin
                v1 = 1; op1 = 2'($urandom_range(0, 3)); imm1 = 16'($urandom);
            end
            step($urandom_range(0, 3) != 0);
            if (acc0) v0 = 0;
            if (acc1) v1 = 0;
        end

        // Drain and confirm every predicted response was delivered
        v0 = 0; v1 = 0;
        repeat (3) step(1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
